// File: rtl/ram_responder.sv
// ram_responder -- word-addressed RAM model with a fixed access latency.
//
// A requester holds ramREN or ramWEN (plus ramaddr/ramstore) until it sees
// ACCESS. Each new request spends LAT cycles in BUSY and then one cycle in
// ACCESS. On the edge that closes a write ACCESS, memory is updated. During a
// read ACCESS, ramload carries the addressed word. A request that is illegal
// reports ERROR for as long as it is held and changes nothing.
//
// Ports
//   CLK       in   single clock, rising edge
//   nRST      in   asynchronous active-low reset (does not clear memory)
//   ramREN    in   read request, held until ACCESS
//   ramWEN    in   write request, held until ACCESS
//   ramaddr   in   byte address; word index = ramaddr[log2(DEPTH)+1:2]
//   ramstore  in   write data
//   ramload   out  read data during a read ACCESS, else 32'hBAD1BAD1
//   ramstate  out  FREE / BUSY / ACCESS / ERROR (combinational)

package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 256
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT_C = 4'(LAT);
    localparam word_t       IDLE_LOAD = 32'hBAD1_BAD1;
    localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) << 2;

    generate
        if (LAT < 1 || LAT > 15) begin : g_bad_lat
            $error("ram_responder: LAT must be in 1..15");
        end
        if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 1) begin : g_bad_depth
            $error("ram_responder: DEPTH must be a power of two");
        end
    endgenerate

    // registered request copy and latency counter
    logic [3:0]  cnt;
    logic [1:0]  op_q;
    word_t       addr_q;
    word_t       data_q;

    logic [1:0]  op;
    logic        req;
    logic        bad;
    logic        changed;
    logic [3:0]  cnt_eff;
    logic [3:0]  cnt_nxt;
    logic [AW-1:0] idx;

    word_t mem [DEPTH];

    assign op  = {ramREN, ramWEN};
    assign req = ramREN | ramWEN;
    assign idx = ramaddr[AW+1:2];

    assign bad = (ramREN & ramWEN)
               | (ramaddr[1:0] != 2'b00)
               | ({32'b0, ramaddr} >= ADDR_LIMIT);

    // The copy holds op=00 after reset or an idle cycle, so any request
    // arriving then is seen as new.
    assign changed = (op != op_q) | (ramaddr != addr_q) | (ramstore != data_q);

    // A changed request is BUSY cycle 0 regardless of what cnt holds, so a
    // switch in the middle of (or right at) an ACCESS cannot complete early.
    assign cnt_eff = changed ? 4'd0 : cnt;

    always_comb begin
        ramstate = FREE;
        if (!req)
            ramstate = FREE;
        else if (bad)
            ramstate = ERROR;
        else if (cnt_eff == LAT_C)
            ramstate = ACCESS;
        else
            ramstate = BUSY;
    end

    always_comb begin
        cnt_nxt = 4'd0;
        case (ramstate)
            BUSY:    cnt_nxt = (cnt_eff >= LAT_C) ? LAT_C : cnt_eff + 4'd1;
            default: cnt_nxt = 4'd0;   // FREE, ERROR, ACCESS
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt    <= 4'd0;
            op_q   <= 2'b00;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            cnt    <= cnt_nxt;
            op_q   <= op;
            addr_q <= ramaddr;
            data_q <= ramstore;
        end
    end

    // No reset on the array: contents survive nRST. While nRST is low the
    // copy is cleared, so every request looks new (BUSY) and ACCESS cannot
    // occur -- which is what keeps an aborted write from landing.
    always_ff @(posedge CLK) begin
        if (ramstate == ACCESS && ramWEN)
            mem[idx] <= ramstore;
    end

    always_comb begin
        ramload = IDLE_LOAD;
        if (ramstate == ACCESS && ramREN)
            ramload = mem[idx];
    end

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    localparam word_t IDLE = 32'hBAD1_BAD1;

    ram_responder #(.LAT(2), .DEPTH(256)) dut (
        .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int        step;
        ramstate_t st;
        word_t     ld;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    // One cycle of stimulus; expected response is queued for the monitor.
    task automatic cyc(input logic rst, input logic r, input logic w,
                       input word_t a, input word_t d,
                       input ramstate_t es, input word_t el);
        exp_t e;
        @(posedge CLK);
        #1;
        nRST = rst; ramREN = r; ramWEN = w; ramaddr = a; ramstore = d;
        e.step = step_no; e.st = es; e.ld = el;
        q.push_back(e);
        step_no++;
    endtask

    task automatic idle();
        cyc(1, 0, 0, 32'h0, 32'h0, FREE, IDLE);
    endtask

    // write held through BUSY,BUSY,ACCESS, then one idle cycle
    task automatic wr(input word_t a, input word_t d);
        cyc(1, 0, 1, a, d, BUSY, IDLE);
        cyc(1, 0, 1, a, d, BUSY, IDLE);
        cyc(1, 0, 1, a, d, ACCESS, IDLE);
        idle();
    endtask

    task automatic rd(input word_t a, input word_t v);
        cyc(1, 1, 0, a, 32'h0, BUSY, IDLE);
        cyc(1, 1, 0, a, 32'h0, BUSY, IDLE);
        cyc(1, 1, 0, a, 32'h0, ACCESS, v);
        idle();
    endtask

    // monitor: compares every presented output against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (ramstate !== e.st) begin
                    errors++;
                    $display("FAIL ramstate step %0d: got %s want %s",
                             e.step, ramstate.name(), e.st.name());
                end
                checks++;
                if (ramload !== e.ld) begin
                    errors++;
                    $display("FAIL ramload step %0d: got %h want %h",
                             e.step, ramload, e.ld);
                end
            end
        end
    end

    initial begin
        nRST = 1'b0; ramREN = 0; ramWEN = 0; ramaddr = 0; ramstore = 0;

        // reset, idle and with a legal request held
        cyc(0, 0, 0, 32'h0, 32'h0, FREE, IDLE);
        cyc(0, 1, 0, 32'h10, 32'h0, BUSY, IDLE);
        cyc(0, 0, 0, 32'h0, 32'h0, FREE, IDLE);

        // write then read back
        idle();
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, 32'hDEAD_BEEF);

        // seed known values
        wr(32'h20, 32'hCAFE_F00D);
        wr(32'h00, 32'h0000_A5A5);
        wr(32'h14, 32'h1414_1414);
        wr(32'h30, 32'h0000_3030);
        wr(32'h3FC, 32'hFFFF_0001);   // last word

        // read+write together -> ERROR while held, memory untouched
        cyc(1, 1, 1, 32'h20, 32'h1111_1111, ERROR, IDLE);
        cyc(1, 1, 1, 32'h20, 32'h1111_1111, ERROR, IDLE);
        cyc(1, 1, 1, 32'h20, 32'h1111_1111, ERROR, IDLE);
        idle();
        rd(32'h20, 32'hCAFE_F00D);

        // misaligned and out-of-range writes
        cyc(1, 0, 1, 32'h13, 32'h5555_5555, ERROR, IDLE);
        cyc(1, 0, 1, 32'h13, 32'h5555_5555, ERROR, IDLE);
        cyc(1, 0, 1, 32'h13, 32'h5555_5555, ERROR, IDLE);
        cyc(1, 0, 1, 32'h400, 32'h6666_6666, ERROR, IDLE);
        cyc(1, 0, 1, 32'h400, 32'h6666_6666, ERROR, IDLE);
        cyc(1, 0, 1, 32'h400, 32'h6666_6666, ERROR, IDLE);
        cyc(1, 1, 0, 32'h401, 32'h0, ERROR, IDLE);
        idle();
        rd(32'h10, 32'hDEAD_BEEF);
        rd(32'h00, 32'h0000_A5A5);
        rd(32'h3FC, 32'hFFFF_0001);

        // address change restarts the count
        cyc(1, 1, 0, 32'h10, 32'h0, BUSY, IDLE);
        cyc(1, 1, 0, 32'h14, 32'h0, BUSY, IDLE);
        cyc(1, 1, 0, 32'h14, 32'h0, BUSY, IDLE);
        cyc(1, 1, 0, 32'h14, 32'h0, ACCESS, 32'h1414_1414);
        // switch right after ACCESS: new address is BUSY cycle 0
        cyc(1, 1, 0, 32'h10, 32'h0, BUSY, IDLE);
        cyc(1, 1, 0, 32'h10, 32'h0, BUSY, IDLE);
        cyc(1, 1, 0, 32'h10, 32'h0, ACCESS, 32'hDEAD_BEEF);
        idle();

        // write data change mid-request restarts too
        cyc(1, 0, 1, 32'h14, 32'h0000_0001, BUSY, IDLE);
        cyc(1, 0, 1, 32'h14, 32'h0000_0002, BUSY, IDLE);
        cyc(1, 0, 1, 32'h14, 32'h0000_0002, BUSY, IDLE);
        cyc(1, 0, 1, 32'h14, 32'h0000_0002, ACCESS, IDLE);
        idle();
        rd(32'h14, 32'h0000_0002);

        // reset aborts a write in its second BUSY cycle
        cyc(1, 0, 1, 32'h30, 32'h1234_5678, BUSY, IDLE);
        cyc(0, 0, 1, 32'h30, 32'h1234_5678, BUSY, IDLE);
        idle();
        idle();
        rd(32'h30, 32'h0000_3030);

        // request held across reset restarts at BUSY cycle 0
        cyc(1, 1, 0, 32'h20, 32'h0, BUSY, IDLE);
        cyc(0, 1, 0, 32'h20, 32'h0, BUSY, IDLE);
        cyc(1, 1, 0, 32'h20, 32'h0, BUSY, IDLE);
        cyc(1, 1, 0, 32'h20, 32'h0, BUSY, IDLE);
        cyc(1, 1, 0, 32'h20, 32'h0, ACCESS, 32'hCAFE_F00D);
        idle();

        // continuous read: ACCESS every third cycle
        for (int i = 0; i < 9; i++)
            cyc(1, 1, 0, 32'h10, 32'h0,
                (i % 3 == 2) ? ACCESS : BUSY,
                (i % 3 == 2) ? 32'hDEAD_BEEF : IDLE);
        idle();

        // drain the scoreboard (bounded)
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
